// File: rtl/fifo_uart_tx_if.sv
// Byte-FIFO read port as seen by a drain stage: empty flag, read strobe, read data.
interface fifo_uart_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              fifo_empty;
    logic              fifo_rd;
    logic [DATA_W-1:0] fifo_dout;

    // master pops the FIFO; slave is the FIFO itself
    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains the upstream byte FIFO one byte at a time and serialises it as UART 8N1, LSB first.
// Bit timing is derived from clk with a CLKS_PER_BIT counter.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;

    // All outputs are registered; tx is loaded with the value of the bit being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            fifo.fifo_rd <= 1'b0;
        end else begin
            fifo.fifo_rd <= 1'b0;
            frame_done   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (enable && !fifo.fifo_empty) begin
                        state        <= S_FETCH;
                        fifo.fifo_rd <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                // FIFO read data is valid in the cycle after the read strobe
                S_LOAD: begin
                    shreg <= fifo.fifo_dout;
                    cnt   <= '0;
                    tx    <= 1'b0;
                    state <= S_START;
                end
                S_START: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        tx    <= shreg[0];
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {1'b0, shreg[DATA_W-1:1]};
                        if (idx == IDX_LAST) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                            tx  <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // frame_done is set one cycle early so it lands on the last stop cycle
                S_STOP: begin
                    tx <= 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_PRE) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural byte FIFO, line sampler, and a byte scoreboard.
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic tx;
    logic busy;
    logic frame_done;

    fifo_uart_tx_if #(.DATA_W(8)) fif ();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo       (fif.master),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO: bench writes mem/wr_ptr, the read process owns rd_ptr.
    logic [7:0] mem [64];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         rd_on_empty = 0;
    logic [7:0] exp_q [$];

    assign fif.fifo_empty = (wr_ptr == rd_ptr);

    initial fif.fifo_dout = 8'h00;

    always @(posedge clk) begin
        if (fif.fifo_rd) begin
            if (wr_ptr == rd_ptr) begin
                rd_on_empty <= rd_on_empty + 1;
            end else begin
                fif.fifo_dout <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + 1;
            end
        end
    end

    // Cycle counter and event monitor, sampled mid-cycle.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   rd_cnt = 0;
    int   dbl_rd = 0;
    int   fd_cnt = 0;
    int   fall_cnt = 0;
    int   fd_cyc [256];
    int   fall_cyc [256];
    logic prev_tx = 1'b1;
    logic prev_rd = 1'b0;

    always @(negedge clk) begin
        prev_tx <= tx;
        prev_rd <= fif.fifo_rd;
        if (fif.fifo_rd) rd_cnt <= rd_cnt + 1;
        if (fif.fifo_rd && prev_rd) dbl_rd <= dbl_rd + 1;
        if (frame_done) begin
            fd_cyc[fd_cnt[7:0]] <= cyc;
            fd_cnt              <= fd_cnt + 1;
        end
        if (prev_tx && !tx) begin
            fall_cyc[fall_cnt[7:0]] <= cyc;
            fall_cnt                <= fall_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit to_sb);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 1;
        if (to_sb) exp_q.push_back(b);
    endtask

    function automatic logic [0:9] make_line(input logic [7:0] b);
        logic [0:9] l;
        l[0] = 1'b0;
        for (int i = 0; i < 8; i++) l[i+1] = b[i];
        l[9] = 1'b1;
        return l;
    endfunction

    function automatic logic [7:0] decode(input logic [0:9] l);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = l[i+1];
        return b;
    endfunction

    // Waits for a start bit, then samples 40 cycles; every cycle of a bit must match its first.
    task automatic recv(input int drop_at, output logic [0:9] line, output bit exact, output bit to);
        int w;
        w     = 0;
        exact = 1'b1;
        to    = 1'b0;
        line  = '1;
        while (tx !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (tx !== 1'b0) begin
            to = 1'b1;
            return;
        end
        for (int c = 0; c < 10 * int'(CPB); c++) begin
            if (c > 0) @(negedge clk);
            if (c == drop_at) enable = 1'b0;
            if (c % int'(CPB) == 0) line[c / int'(CPB)] = tx;
            else if (tx !== line[c / int'(CPB)]) exact = 1'b0;
        end
    endtask

    task automatic recv_chk(input string name, input int drop_at, input logic [0:9] exp_line);
        logic [0:9] line;
        bit         exact;
        bit         to;
        recv(drop_at, line, exact, to);
        chk({name, "_timeout"}, int'(to), 0);
        chk({name, "_line"}, int'(line), int'(exp_line));
        chk({name, "_exact"}, int'(exact), 1);
        if (exp_q.size() == 0) chk({name, "_sb_empty"}, 1, 0);
        else chk({name, "_byte"}, int'(decode(line)), int'(exp_q.pop_front()));
    endtask

    typedef struct {
        logic [7:0] data;
        logic [0:9] line;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int rd0, fd0, f0, push_cyc, bad_tx, bad_busy, w;

        tbl[0] = '{8'hA5, 10'b0101001011};
        tbl[1] = '{8'h00, 10'b0000000001};
        tbl[2] = '{8'hFF, 10'b0111111111};
        tbl[3] = '{8'h3C, 10'b0001111001};
        tbl[4] = '{8'h81, 10'b0100000011};

        rst    = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd", int'(fif.fifo_rd), 0);
        chk("rst_fd", int'(frame_done), 0);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b1;

        // Single frames from the vector table, DUT idle before each
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd0      = rd_cnt;
            fd0      = fd_cnt;
            f0       = fall_cnt;
            push_cyc = cyc;
            push(tbl[i].data, 1'b1);
            recv_chk("vec", -1, tbl[i].line);
            repeat (4) @(negedge clk);
            #1;
            chk("vec_rd_pulses", rd_cnt - rd0, 1);
            chk("vec_fd_pulses", fd_cnt - fd0, 1);
            chk("vec_start_latency", fall_cyc[f0[7:0]] - push_cyc, 3);
            // frame_done sits on the 40th line cycle counted from the falling edge
            chk("vec_fd_pos", fd_cyc[fd0[7:0]] - fall_cyc[f0[7:0]], 10 * int'(CPB) - 1);
            chk("vec_busy_end", int'(busy), 0);
        end

        // Back-to-back 0x00 then 0xFF
        @(negedge clk);
        rd0 = rd_cnt;
        fd0 = fd_cnt;
        f0  = fall_cnt;
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        recv_chk("b2b0", -1, 10'b0000000001);
        recv_chk("b2b1", -1, 10'b0111111111);
        repeat (4) @(negedge clk);
        #1;
        chk("b2b_rd_pulses", rd_cnt - rd0, 2);
        chk("b2b_gap", fall_cyc[(f0 + 1) & 255] - fd_cyc[fd0[7:0]], 4);

        // Empty FIFO with enable high
        rd0      = rd_cnt;
        bad_tx   = 0;
        bad_busy = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        #1;
        chk("empty_rd", rd_cnt - rd0, 0);
        chk("empty_tx_low", bad_tx, 0);
        chk("empty_busy", bad_busy, 0);

        // enable dropped during DATA of the first of three queued bytes
        rd0 = rd_cnt;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        recv_chk("en_drop", 3 * int'(CPB) + 1, make_line(8'h11));
        repeat (30) @(negedge clk);
        #1;
        chk("en_drop_rd", rd_cnt - rd0, 1);
        chk("en_drop_busy", int'(busy), 0);
        chk("en_drop_tx", int'(tx), 1);
        enable = 1'b1;
        recv_chk("en_resume2", -1, make_line(8'h22));
        recv_chk("en_resume3", -1, make_line(8'h33));

        // Reset during DATA: 0x5A drives 0 on data bit 2, byte is lost
        repeat (4) @(negedge clk);
        push(8'h5A, 1'b0);
        w = 0;
        while (tx !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("rst_mid_start_seen", int'(tx), 0);
        repeat (3 * CPB) @(negedge clk);
        chk("rst_mid_pre_tx", int'(tx), 0);
        rst = 1'b0;
        #1;
        chk("rst_mid_async_tx", int'(tx), 1);
        chk("rst_mid_async_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid_idle_busy", int'(busy), 0);
        chk("rst_mid_idle_tx", int'(tx), 1);
        push(8'hC3, 1'b1);
        recv_chk("rst_after", -1, make_line(8'hC3));

        // Sixteen bytes filling the FIFO
        repeat (4) @(negedge clk);
        rd0 = rd_cnt;
        fd0 = fd_cnt;
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        for (int i = 0; i < 16; i++) recv_chk("fill", -1, make_line(8'(i)));
        repeat (10) @(negedge clk);
        #1;
        chk("fill_rd_pulses", rd_cnt - rd0, 16);
        chk("fill_fd_pulses", fd_cnt - fd0, 16);
        chk("fill_sb_left", exp_q.size(), 0);
        chk("rd_on_empty", rd_on_empty, 0);
        chk("rd_back_to_back", dbl_rd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drain stage placed directly downstream of the team's 8-bit, 16-deep byte FIFO.
- Pops one byte at a time through the FIFO's rd/empty interface.
- Serialises each byte onto a UART 8N1 line, LSB first.
- Runs on the FIFO's clock domain. Pacing comes from a parameterised clocks-per-bit counter, so no separate baud clock is needed.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit. Legal range 2..65535; the counter width is derived from it.
- DATA_W, 8, byte width. Fixed at 8 for this revision; present only so the width is named.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  1 = start new frames when data is available; 0 = finish the current frame, then idle.
- fifo_empty  input  1  empty flag from the upstream FIFO.
- fifo_dout  input  DATA_W  read data from the upstream FIFO; sampled one cycle after the fifo_rd pulse.
- fifo_rd  output  1  registered, single-cycle read request to the FIFO.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high from FETCH entry through the last STOP cycle.
- frame_done  output  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, fifo_rd=0, busy=0, frame_done=0.
  - state=IDLE; baud counter, bit index and shift register cleared.
- Reset asserted mid-frame: the frame is abandoned immediately, tx returns to 1 without waiting for a clock, and the byte is lost.
- State machine states: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1.
  - On an edge with enable=1 and fifo_empty=0, go to FETCH.
- FETCH: lasts exactly one cycle, with fifo_rd=1. Then go to LOAD.
- LOAD: lasts one cycle. On the exiting edge, shreg <= fifo_dout, then go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1; wrap → DATA with bit index 0.
- DATA:
  - tx=shreg[0].
  - On each counter wrap: shreg shifts right and bit index increments.
  - After the 8th bit (index 7 wrap), go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 in the last cycle.
  - Then go to IDLE.
- Timing:
  - tx falls on the 2nd rising edge after the edge where IDLE samples fifo_empty=0 (FETCH and LOAD cycles in between).
  - Frame on the line = 10*CLKS_PER_BIT cycles.
  - Back-to-back frames: the minimum gap between the end of a stop bit and the next start bit is 3 cycles of idle-high (IDLE, FETCH, LOAD). This gap is accepted.
- fifo_rd rules:
  - Never asserted unless fifo_empty was 0 on the edge that entered FETCH.
  - Never asserted for two consecutive cycles.
  - Exactly one pulse per frame.
- fifo_empty and enable are ignored outside IDLE. If enable drops mid-frame, the frame completes and the block then stays in IDLE.
- Counter arithmetic: the baud counter is unsigned with width clog2(CLKS_PER_BIT). The compare is against CLKS_PER_BIT-1; there is no reliance on natural overflow.
- busy is a registered decode of state != IDLE.

Test Plan:
- CLKS_PER_BIT=4, FIFO preloaded with 0xA5, enable=1:
  - exactly one fifo_rd pulse;
  - tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1;
  - frame_done pulses once at cycle 40 after tx falls;
  - busy returns to 0.
- Back-to-back 0x00 then 0xFF:
  - two fifo_rd pulses;
  - second start bit begins exactly 3 cycles after the first stop bit ends;
  - data bits are all 0, then all 1.
- fifo_empty=1 held for 200 cycles with enable=1: fifo_rd never asserts, tx stays 1, busy stays 0.
- enable dropped during DATA of frame 1 with 3 bytes queued:
  - frame 1 completes with a bit-exact waveform;
  - no further fifo_rd;
  - re-raising enable resumes with byte 2.
- rst pulled low mid-DATA:
  - tx=1 asynchronously, before the next clk edge;
  - after release the block sits in IDLE and starts cleanly on the next non-empty byte.
- 16 bytes (0x00..0x0F) fill the FIFO:
  - exactly 16 fifo_rd pulses and 16 frame_done pulses;
  - decoded bytes arrive in order;
  - no read is issued after fifo_empty rises.
